// File: rtl/mem_data_skew_pkg.sv
// Shared definitions for the systolic-array memory skew/de-skew block.
package mem_data_skew_pkg;

  typedef enum logic {
    MODE_SKEW   = 1'b0,
    MODE_DESKEW = 1'b1
  } mode_e;

  // Delay in cycles seen by one lane in the given mode.
  function automatic int lane_delay(input int lane, input int array,
                                    input int base_dly, input logic mode);
    return (mode == MODE_DESKEW) ? (array - 1 - lane + base_dly) : (lane + base_dly);
  endfunction

endpackage

// File: rtl/mem_data_skew_lane.sv
// One lane: a valid chain spanning the full delay range, a data chain just deep
// enough for this lane's furthest tap, and a mode-selected output tap.
module mem_skew_lane
  import mem_data_skew_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ARRAY        = 32,
  parameter int BASE_DLY     = 1,
  parameter int ZERO_INVALID = 1,
  parameter int LANE         = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  mode_act,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int MAX_DLY    = ARRAY - 1 + BASE_DLY;
  localparam int SKEW_TAP   = lane_delay(LANE, ARRAY, BASE_DLY, MODE_SKEW) - 1;
  localparam int DESKEW_TAP = lane_delay(LANE, ARRAY, BASE_DLY, MODE_DESKEW) - 1;
  localparam int DATA_DEPTH = ((SKEW_TAP > DESKEW_TAP) ? SKEW_TAP : DESKEW_TAP) + 1;

  logic [MAX_DLY-1:0]    valid_q;
  logic [DATA_WIDTH-1:0] data_q [DATA_DEPTH];

  // NOTE: sequential state uses non-blocking (<=) so every stage samples its
  // neighbour's pre-edge value; blocking here would collapse the shift chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      // NOTE: the data stages are cleared too because the taps feed data_out
      // directly, and data_out must read zero after reset even with ZERO_INVALID=0.
      for (int k = 0; k < DATA_DEPTH; k++) data_q[k] <= '0;
    end else if (!stall) begin
      valid_q   <= {valid_q[MAX_DLY-2:0], in_valid};
      data_q[0] <= data_in;
      for (int k = 1; k < DATA_DEPTH; k++) data_q[k] <= data_q[k-1];
    end
  end

  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;

  assign sel_valid = (mode_act == MODE_DESKEW) ? valid_q[DESKEW_TAP] : valid_q[SKEW_TAP];
  assign sel_data  = (mode_act == MODE_DESKEW) ? data_q[DESKEW_TAP]  : data_q[SKEW_TAP];

  assign out_valid = sel_valid;
  assign data_out  = ((ZERO_INVALID != 0) && !sel_valid) ? '0 : sel_data;
  assign busy      = |valid_q;

endmodule

// File: rtl/mem_data_skew.sv
// Per-lane skew/de-skew of a wide memory word; mode switches only when idle.
module mem_data_skew
  import mem_data_skew_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ARRAY        = 32,
  parameter int BASE_DLY     = 1,
  parameter int ZERO_INVALID = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        mode_req,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH*ARRAY-1:0] data_in,
  output logic [DATA_WIDTH*ARRAY-1:0] data_out,
  output logic [ARRAY-1:0]            out_valid,
  output logic                        mode_act,
  output logic                        busy
);

  logic [ARRAY-1:0] lane_busy;
  mode_e            mode_q;

  // A pending mode_req is simply re-sampled every edge, so a request made
  // while busy is deferred rather than lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= mode_e'(mode_req);
    end else if (!stall && !busy && !in_valid) begin
      mode_q <= mode_e'(mode_req);
    end
  end

  assign mode_act = mode_q;
  assign busy     = |lane_busy;

  for (genvar n = 0; n < ARRAY; n++) begin : g_lane
    mem_skew_lane #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ARRAY        (ARRAY),
      .BASE_DLY     (BASE_DLY),
      .ZERO_INVALID (ZERO_INVALID),
      .LANE         (n)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .mode_act  (mode_act),
      .in_valid  (in_valid),
      .data_in   (data_in[n*DATA_WIDTH +: DATA_WIDTH]),
      .data_out  (data_out[n*DATA_WIDTH +: DATA_WIDTH]),
      .out_valid (out_valid[n]),
      .busy      (lane_busy[n])
    );
  end

endmodule

// File: tb/tb_mem_data_skew.sv
// Scoreboard bench for mem_data_skew with ARRAY=4, DATA_WIDTH=8, BASE_DLY=1.
module tb_mem_data_skew;

  localparam int DW   = 8;
  localparam int AR   = 4;
  localparam int MAXD = AR;

  typedef struct {
    int       due;
    logic [7:0] data;
  } tok_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               stall = 1'b0;
  logic               mode_req = 1'b1;
  logic               in_valid = 1'b0;
  logic [DW*AR-1:0]   data_in = '0;
  logic [DW*AR-1:0]   data_out;
  logic [AR-1:0]      out_valid;
  logic               mode_act;
  logic               busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  tok_t        lane_q [AR][$];
  int          cnt = 0;
  int          last_push = -1000;
  logic        mode_m = 1'b0;
  logic [3:0]  exp_v = '0;
  logic [31:0] exp_d = '0;

  mem_data_skew #(
    .DATA_WIDTH   (DW),
    .ARRAY        (AR),
    .BASE_DLY     (1),
    .ZERO_INVALID (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .mode_req  (mode_req),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .mode_act  (mode_act),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cnt);
    end
  endtask

  // Drive one cycle, advance the reference model across the edge, then compare.
  task automatic step(input logic rst, input logic st, input logic mr,
                      input logic v, input logic [31:0] d);
    tok_t tok;
    reset = rst; stall = st; mode_req = mr; in_valid = v; data_in = d;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int n = 0; n < AR; n++) lane_q[n].delete();
      last_push = -1000;
      mode_m = mr;
      exp_v = '0;
      exp_d = '0;
    end else if (!st) begin
      if (v) begin
        for (int n = 0; n < AR; n++) begin
          tok.due  = cnt + (mode_m ? (AR - n) : (n + 1));
          tok.data = d[n*8 +: 8];
          lane_q[n].push_back(tok);
        end
      end else if (cnt - last_push > MAXD) begin
        mode_m = mr;
      end
      if (v) last_push = cnt;
      cnt++;
      exp_v = '0;
      exp_d = '0;
      for (int n = 0; n < AR; n++) begin
        if (lane_q[n].size() > 0 && lane_q[n][0].due == cnt) begin
          exp_v[n] = 1'b1;
          exp_d[n*8 +: 8] = lane_q[n][0].data;
          void'(lane_q[n].pop_front());
        end
      end
    end
    check("out_valid", {28'b0, out_valid}, {28'b0, exp_v});
    check("data_out", data_out, exp_d);
    check("busy", {31'b0, busy}, {31'b0, (!rst && (cnt - last_push <= MAXD))});
    check("mode_act", {31'b0, mode_act}, {31'b0, mode_m});
  endtask

  initial begin
    int left;
    // Reset into DESKEW.
    step(1, 0, 1, 0, '0);
    step(1, 0, 1, 0, '0);
    // Single DESKEW token.
    step(0, 0, 1, 1, 32'h44332211);
    repeat (5) step(0, 0, 1, 0, '0);
    // Idle switch to SKEW, then a single SKEW token.
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, 32'h44332211);
    repeat (6) step(0, 0, 0, 0, '0);
    // Eight back-to-back words with a 3-cycle stall (in_valid ignored while stalled).
    for (int i = 0; i < 8; i++) begin
      if (i == 4) repeat (3) step(0, 1, 0, 1, $urandom);
      step(0, 0, 0, 1, $urandom);
    end
    repeat (8) step(0, 0, 0, 0, '0);
    // Mode request while busy is deferred; in-flight tokens keep SKEW timing.
    step(0, 0, 0, 1, 32'hA4A3A2A1);
    step(0, 0, 1, 1, 32'hB4B3B2B1);
    repeat (7) step(0, 0, 1, 0, '0);
    // A valid word on the qualifying edge blocks the switch back to SKEW.
    step(0, 0, 0, 1, 32'hC4C3C2C1);
    repeat (6) step(0, 0, 0, 0, '0);
    // Reset with three tokens in flight.
    step(0, 0, 0, 1, 32'hD4D3D2D1);
    step(0, 0, 0, 1, 32'hE4E3E2E1);
    step(0, 0, 0, 1, 32'hF4F3F2F1);
    step(1, 0, 1, 0, '0);
    repeat (6) step(0, 0, 1, 0, '0);
    // Reset and stall together: reset wins.
    step(0, 0, 1, 1, 32'h11223344);
    step(0, 0, 1, 1, 32'h55667788);
    step(1, 1, 0, 0, '0);
    repeat (5) step(0, 0, 0, 0, '0);
    left = 0;
    for (int n = 0; n < AR; n++) left += lane_q[n].size();
    check("drained", left, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_data_skew.md
MEM_DATA_SKEW -- requirements
Module: mem_data_skew

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per lane.
REQ-002 Parameter ARRAY, default 32: number of lanes; legal range 2..64.
REQ-003 Parameter BASE_DLY, default 1: minimum lane delay in cycles; legal range 1..4.
REQ-004 Parameter ZERO_INVALID, default 1: when 1, lanes without a valid output drive zero.
REQ-005 Derived MEM_DATA_WIDTH = DATA_WIDTH*ARRAY; MAX_DLY = ARRAY-1+BASE_DLY.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 stall  input  1  when 1, all internal state holds.
REQ-009 mode_req  input  1  requested mode: 0 = SKEW, 1 = DESKEW.
REQ-010 in_valid  input  1  data_in word is valid this cycle.
REQ-011 data_in  input  MEM_DATA_WIDTH  lane n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-012 data_out  output  MEM_DATA_WIDTH  delayed lanes, same packing as data_in.
REQ-013 out_valid  output  ARRAY  per-lane valid for data_out.
REQ-014 mode_act  output  1  mode currently in effect.
REQ-015 busy  output  1  1 while any valid token is in flight in any lane.

Function
REQ-016 Lane n delay SHALL be n+BASE_DLY cycles in SKEW and ARRAY-1-n+BASE_DLY cycles in DESKEW, counted in non-stalled cycles.
REQ-017 DESKEW with BASE_DLY=1 SHALL delay lane n by exactly ARRAY-n cycles (legacy output de-skew timing).
REQ-018 Each lane SHALL carry a valid bit alongside its data through a MAX_DLY-stage shift chain; the output tap is selected by mode_act.
REQ-019 in_valid=0 SHALL inject an invalid token; data_in SHALL still be shifted but flagged invalid.
REQ-020 out_valid[n] SHALL equal the valid bit at lane n's selected tap.
REQ-021 With ZERO_INVALID=1, data_out lane n SHALL be zero whenever out_valid[n]=0; with ZERO_INVALID=0 it shows the raw tap.
REQ-022 stall=1 SHALL freeze all chains, mode_act and busy; outputs hold their previous values; in_valid is ignored.
REQ-023 busy SHALL be the OR of all valid bits held in all chain stages (registered state, no input term).
REQ-024 mode_act SHALL update to mode_req on a non-stalled edge only when busy=0 and in_valid=0; otherwise it holds.
REQ-025 A mode_req change while busy=1 SHALL be deferred, not dropped; it takes effect on the first qualifying edge.
REQ-026 in_valid=1 in the same cycle a mode change would qualify SHALL block the change; the token uses the old mode_act.
REQ-027 Back-to-back valid words SHALL be accepted every non-stalled cycle with no bubbles; throughput is one word per cycle.

Reset
REQ-028 reset=1 SHALL clear all valid bits, set busy=0 and out_valid=0, and set data_out=0 regardless of ZERO_INVALID.
REQ-029 reset SHALL load mode_act from mode_req.
REQ-030 reset SHALL take priority over stall.
REQ-031 Reset mid-stream SHALL discard all in-flight tokens; chain data registers need not be cleared except where they drive outputs.

Structure
REQ-032 Mode encodings MODE_SKEW=0 and MODE_DESKEW=1 SHALL live in the shared systolic-array package.
REQ-033 One sub-module, mem_skew_lane, SHALL implement one lane: a MAX_DLY-deep data+valid chain with two static taps and a mode select; the top instantiates ARRAY copies.
REQ-034 The lane tap indices SHALL be elaboration-time constants; there are no run-time variable shifters.

Verification (ARRAY=4, DATA_WIDTH=8, BASE_DLY=1, ZERO_INVALID=1)
REQ-035 DESKEW: apply data_in=0x44332211 with in_valid=1 for 1 cycle -> out_valid pulses 0x1 at +4, 0x2 at +3, 0x4 at +2, 0x8 at +1 cycles; the valid lane shows 0x11, 0x22, 0x33 or 0x44 respectively, and other lanes show 0.
REQ-036 SKEW: apply the same stimulus -> lane0 0x11 at +1, lane1 0x22 at +2, lane2 0x33 at +3, lane3 0x44 at +4; busy falls the cycle after lane3 is output.
REQ-037 Stream 8 consecutive words with stall asserted for 3 cycles mid-stream -> every lane's output sequence is unchanged and each lane's latency grows by exactly 3 cycles.
REQ-038 Toggle mode_req 0->1 while busy=1 -> mode_act stays 0 until busy=0 with in_valid=0, then becomes 1 one edge later; in-flight tokens exit with SKEW timing.
REQ-039 Assert reset for 1 cycle with 3 tokens in flight -> the next cycle shows out_valid=0, data_out=0 and busy=0, and no stale token ever appears.
REQ-040 Assert reset and stall together -> the reset values appear and the freeze is ignored.
